// File: rtl/rv32i_hazard_ctl.sv
// Forwarding mux with NSRC prioritised sources, load-use interlock and jump-flush sequencing.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module rv32i_hazard_ctl #(
  parameter int XLEN      = 32,
  parameter int NSRC      = 3,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           rs1_reg,
  input  logic [4:0]           rs2_reg,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [XLEN-1:0]      rf_rs1_data,
  input  logic [XLEN-1:0]      rf_rs2_data,
  input  logic [NSRC-1:0]      df_enable,
  input  logic [5*NSRC-1:0]    df_reg,
  input  logic [XLEN*NSRC-1:0] df_data,
  input  logic [NSRC-1:0]      df_is_load,
  input  logic                 jump_en,
  output logic [XLEN-1:0]      rs1_data_out,
  output logic [XLEN-1:0]      rs2_data_out,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 flush_if_id,
  output logic                 jump_accept,
  output logic [1:0]           state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     fwd_cnt
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [2:0] LL_M1 = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FC_M1 = 3'(FLUSH_CYC - 1);

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;
  logic            w_rs1_hit, w_rs2_hit, w_rs1_fwd, w_rs2_fwd;
  logic [XLEN-1:0] w_rs1_df, w_rs2_df;
  logic            w_lu, w_stall, w_accept, w_flush;

  // Walk oldest to youngest so the lowest matching index wins.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    w_rs1_df  = '0;
    w_rs2_df  = '0;
    w_lu      = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (df_enable[i] && df_reg[5*i +: 5] == rs1_reg) begin
        w_rs1_hit = 1'b1;
        w_rs1_df  = df_data[XLEN*i +: XLEN];
      end
      if (df_enable[i] && df_reg[5*i +: 5] == rs2_reg) begin
        w_rs2_hit = 1'b1;
        w_rs2_df  = df_data[XLEN*i +: XLEN];
      end
      if (df_enable[i] && df_is_load[i] &&
          ((rs1_used && rs1_reg != 5'd0 && df_reg[5*i +: 5] == rs1_reg) ||
           (rs2_used && rs2_reg != 5'd0 && df_reg[5*i +: 5] == rs2_reg)))
        w_lu = 1'b1;
    end
    w_lu = w_lu & id_valid;
  end

  assign w_rs1_fwd    = w_rs1_hit && (rs1_reg != 5'd0);
  assign w_rs2_fwd    = w_rs2_hit && (rs2_reg != 5'd0);
  assign rs1_data_out = (rs1_reg == 5'd0) ? '0 : (w_rs1_hit ? w_rs1_df : rf_rs1_data);
  assign rs2_data_out = (rs2_reg == 5'd0) ? '0 : (w_rs2_hit ? w_rs2_df : rf_rs2_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_lu) begin
          if (LOAD_LAT > 1) begin
            w_state_nxt = STALL;
            w_cnt_nxt   = LL_M1;
          end
        end else if (jump_en && FLUSH_CYC > 1) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = FC_M1;
        end
      end
      STALL, FLUSH: begin
        if (r_cnt <= 3'd1) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Controls are held low for the whole reset window, even with a hazard present.
  always_comb begin
    w_stall  = !reset && (((r_state == RUN) && w_lu) || (r_state == STALL));
    w_accept = !reset && (r_state == RUN) && !w_lu && jump_en;
    w_flush  = w_accept || (!reset && (r_state == FLUSH));
  end

  assign stall_if    = w_stall;
  assign stall_id    = w_stall;
  assign bubble_ex   = w_stall;
  assign flush_if_id = w_flush;
  assign jump_accept = w_accept;
  assign state_o     = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_fwd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_accept && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (id_valid && (w_rs1_fwd || w_rs2_fwd) && r_fwd_cnt != '1)
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule
